midi_msg_rx: RTL and testbench

- Parametrised next-generation MIDI input block.
- Deserialises the MIDI serial line and parses bytes into complete messages, handling running status, real-time interleave and a per-channel filter.
- Buffers whole 24-bit messages in an internal first-word-fall-through FIFO so the synth core pops one message per read instead of raw bytes.

---
 rtl/midi_msg_pkg.sv | 51 +++++
 rtl/midi_byte_rx.sv | 89 ++++++++
 rtl/midi_msg_rx.sv | 165 ++++++++++++++++
 tb/tb_midi_msg_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_msg_pkg.sv
// Shared types, status-byte constants and length decode for the MIDI message receiver.
// MIDI_MSG_TIMESTAMP_EN adds a 16-bit millisecond timestamp to every stored message.
package midi_msg_pkg;

`ifdef MIDI_MSG_TIMESTAMP_EN
    localparam int MSG_W = 40;
`else
    localparam int MSG_W = 24;
`endif

    typedef struct packed {
`ifdef MIDI_MSG_TIMESTAMP_EN
        logic [15:0] ts;
`endif
        logic [7:0]  status;
        logic [7:0]  data1;
        logic [7:0]  data2;
    } midi_msg_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [7:0] ST_NOTE_OFF  = 8'h80;
    localparam logic [7:0] ST_NOTE_ON   = 8'h90;
    localparam logic [7:0] ST_POLY_AT   = 8'hA0;
    localparam logic [7:0] ST_CTRL      = 8'hB0;
    localparam logic [7:0] ST_PROG      = 8'hC0;
    localparam logic [7:0] ST_CHAN_AT   = 8'hD0;
    localparam logic [7:0] ST_PITCH     = 8'hE0;
    localparam logic [7:0] ST_SYSEX     = 8'hF0;
    localparam logic [7:0] ST_MTC       = 8'hF1;
    localparam logic [7:0] ST_SPP       = 8'hF2;
    localparam logic [7:0] ST_SONG_SEL  = 8'hF3;
    localparam logic [7:0] ST_TUNE      = 8'hF6;
    localparam logic [7:0] ST_EOX       = 8'hF7;
    localparam logic [7:0] RT_BASE      = 8'hF8;

    // Number of data bytes following a status byte; 0 also marks "cannot be running status".
    function automatic logic [1:0] data_len(input logic [7:0] status);
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2'd2;
            4'hC, 4'hD:                   return 2'd1;
            4'hF: begin
                if (status == ST_MTC || status == ST_SONG_SEL) return 2'd1;
                if (status == ST_SPP)                          return 2'd2;
                return 2'd0;
            end
            default:                      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/midi_byte_rx.sv
// MIDI UART byte receiver: synchroniser, start/data/stop FSM, mid-bit sampling.
// Latency: byte_valid pulses in the cycle of the stop-bit sample.
// Backpressure: none; bytes are delivered as pulses and must be consumed immediately.
module midi_byte_rx
    import midi_msg_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 31250,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_prev;
    logic                   line;
    logic                   fall;
    logic [CW-1:0]          bit_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic                   tick;
    rx_state_t              state, state_nxt;

    assign line = sync_q[SYNC_STAGES-1];
    assign fall = line_prev & ~line;
    assign tick = (bit_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
            line_prev <= line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (tick) state_nxt = line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (tick) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // Counter holds the half-bit preload while idle so the start bit is sampled mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= CW'(DIV / 2);
            bit_idx <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            if (state == RX_IDLE)  bit_cnt <= CW'(DIV / 2);
            else if (tick)         bit_cnt <= CW'(DIV - 1);
            else                   bit_cnt <= bit_cnt - CW'(1);

            if (state != RX_DATA)  bit_idx <= 3'd0;
            else if (tick)         bit_idx <= bit_idx + 3'd1;

            if (state == RX_DATA && tick) shift_q <= {line, shift_q[7:1]};
        end
    end

    always_comb begin
        rx_byte         = shift_q;
        byte_valid      = 1'b0;
        frame_err_pulse = 1'b0;
        if (state == RX_STOP && tick) begin
            byte_valid      = line;
            frame_err_pulse = ~line;
        end
    end

endmodule

// File: rtl/midi_msg_rx.sv
// MIDI input: bytes -> complete messages (running status, real-time, channel filter) -> message FIFO.
// Latency: msg_valid one cycle after the stop sample, FIFO write on the next edge (empty falls 2 cycles after).
// Backpressure: none upstream; a full FIFO drops the message and sets sticky overflow. MIDI_MSG_TIMESTAMP_EN adds ms timestamps.
module midi_msg_rx
    import midi_msg_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 31250,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            din,
    input  logic [15:0]                     chan_mask,
    input  logic                            rd_en,
    output logic [MSG_W-1:0]                dout,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            overflow,
    output logic                            frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err_pulse;

    midi_byte_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk             (clk),
        .rst_n           (reset),
        .din             (din),
        .rx_byte         (rx_byte),
        .byte_valid      (byte_valid),
        .frame_err_pulse (frame_err_pulse)
    );

`ifdef MIDI_MSG_TIMESTAMP_EN
    localparam int MS_DIV = CLK_HZ / 1000;
    logic [31:0] ms_cnt;
    logic [15:0] ts_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_cnt <= '0;
            ts_cnt <= '0;
        end else if (ms_cnt == 32'(MS_DIV - 1)) begin
            ms_cnt <= '0;
            ts_cnt <= ts_cnt + 16'd1;
        end else begin
            ms_cnt <= ms_cnt + 32'd1;
        end
    end
`endif

    // run_st doubles as running status and pending system-common status (0 = none).
    logic [7:0] run_st, run_st_nxt;
    logic [7:0] d1_q, d1_nxt;
    logic       have_q, have_nxt;
    logic       sysex_q, sysex_nxt;
    logic       emit;
    midi_msg_t  em;
    logic       msg_valid;
    midi_msg_t  msg_q;

    always_comb begin
        run_st_nxt = run_st;
        d1_nxt     = d1_q;
        have_nxt   = have_q;
        sysex_nxt  = sysex_q;
        emit       = 1'b0;
        em         = '0;
`ifdef MIDI_MSG_TIMESTAMP_EN
        em.ts      = ts_cnt;
`endif
        if (byte_valid) begin
            if (rx_byte >= RT_BASE) begin
                emit      = 1'b1;
                em.status = rx_byte;
            end else if (rx_byte[7]) begin
                have_nxt   = 1'b0;
                sysex_nxt  = (rx_byte == ST_SYSEX);
                run_st_nxt = (data_len(rx_byte) != 2'd0) ? rx_byte : 8'h00;
                if (rx_byte == ST_TUNE) begin
                    emit      = 1'b1;
                    em.status = rx_byte;
                end
            end else if (!sysex_q && run_st != 8'h00) begin
                if (data_len(run_st) == 2'd1 || have_q) begin
                    em.status = run_st;
                    em.data1  = have_q ? d1_q : rx_byte;
                    em.data2  = have_q ? rx_byte : 8'h00;
                    have_nxt  = 1'b0;
                    emit      = (run_st >= ST_SYSEX) || chan_mask[run_st[3:0]];
                    if (run_st >= ST_SYSEX) run_st_nxt = 8'h00;
                end else begin
                    d1_nxt   = rx_byte;
                    have_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_st    <= 8'h00;
            d1_q      <= 8'h00;
            have_q    <= 1'b0;
            sysex_q   <= 1'b0;
            msg_valid <= 1'b0;
            msg_q     <= '0;
        end else begin
            run_st    <= run_st_nxt;
            d1_q      <= d1_nxt;
            have_q    <= have_nxt;
            sysex_q   <= sysex_nxt;
            msg_valid <= emit;
            msg_q     <= em;
        end
    end

    midi_msg_t   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          do_rd, do_wr;

    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);
    assign count = cnt;
    assign dout  = empty ? '0 : mem[rd_ptr];
    assign do_rd = rd_en && !empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign do_wr = msg_valid && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= msg_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (msg_valid && !do_wr) overflow <= 1'b1;
            if (frame_err_pulse)     frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_midi_msg_rx.sv
// Directed bench for midi_msg_rx: serial byte stimulus, hand-computed FIFO contents and flags.
module tb_midi_msg_rx;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 31250;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din = 1'b1;
    logic        rd_en = 1'b0;
    logic [15:0] chan_mask = 16'hFFFF;
    logic [midi_msg_pkg::MSG_W-1:0] dout;
    logic        empty, full, overflow, frame_err;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bv_cyc = -1;
    int fall_cyc = -1;
    logic empty_d = 1'b1;

    midi_msg_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .chan_mask (chan_mask),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dut.u_byte_rx.byte_valid) bv_cyc = cyc;
        if (empty_d && !empty) fall_cyc = cyc;
        empty_d = empty;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        din = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        din = stop_bit;
        repeat (DIV) @(posedge clk);
        #1;
        din = 1'b1;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [23:0] exp);
        check_eq({tag, "_nonempty"}, 64'(empty), 64'd0);
        check_eq(tag, 64'(dout), 64'(exp));
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    initial begin
        #1;
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_frame_err", 64'(frame_err), 64'd0);
        check_eq("rst_dout", 64'(dout), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // single note-on and write latency
        send3(8'h90, 8'h3C, 8'h64);
        settle();
        check_eq("t1_count", 64'(count), 64'd1);
        check_eq("t1_latency", 64'(fall_cyc - bv_cyc), 64'd2);
        pop_chk("t1_msg", 24'h903C64);
        check_eq("t1_empty_after", 64'(empty), 64'd1);

        // running status
        send3(8'h90, 8'h3C, 8'h64);
        send_byte(8'h3E, 1'b1);
        send_byte(8'h50, 1'b1);
        settle();
        check_eq("t2_count", 64'(count), 64'd2);
        pop_chk("t2_msg0", 24'h903C64);
        pop_chk("t2_msg1", 24'h903E50);

        // real-time byte interleaved inside a message
        send_byte(8'h90, 1'b1);
        send3(8'h3C, 8'hF8, 8'h64);
        settle();
        pop_chk("t3_rt", 24'hF80000);
        pop_chk("t3_msg", 24'h903C64);

        // channel filter
        chan_mask = 16'h0001;
        send3(8'h91, 8'h40, 8'h40);
        send_byte(8'hC0, 1'b1);
        send_byte(8'h05, 1'b1);
        settle();
        check_eq("t4_count", 64'(count), 64'd1);
        pop_chk("t4_msg", 24'hC00500);
        chan_mask = 16'hFFFF;

        // sysex is swallowed, then a normal message, then a lone data byte
        send_byte(8'hF0, 1'b1);
        send3(8'h7E, 8'h01, 8'hF7);
        send3(8'hB0, 8'h07, 8'h7F);
        send_byte(8'h10, 1'b1);
        settle();
        check_eq("t5_count", 64'(count), 64'd1);
        pop_chk("t5_msg", 24'hB0077F);
        check_eq("t5_empty_after", 64'(empty), 64'd1);

        // fill to full with program changes under running status, then overflow
        send_byte(8'hC5, 1'b1);
        for (int d = 1; d <= DEPTH; d++) send_byte(8'(d), 1'b1);
        settle();
        check_eq("t6_full_pre", 64'(full), 64'd1);
        check_eq("t6_overflow_pre", 64'(overflow), 64'd0);
        send_byte(8'(DEPTH + 1), 1'b1);
        settle();
        check_eq("t6_full", 64'(full), 64'd1);
        check_eq("t6_count", 64'(count), 64'd16);
        check_eq("t6_overflow", 64'(overflow), 64'd1);
        pop_chk("t6_head", 24'hC50100);
        check_eq("t6_count_pop", 64'(count), 64'd15);
        rd_en = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        rd_en = 1'b0;
        check_eq("t6_count_tail", 64'(count), 64'd1);
        pop_chk("t6_tail", 24'hC51000);
        check_eq("t6_drained", 64'(empty), 64'd1);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check_eq("t6_rd_empty", 64'(count), 64'd0);

        // framing error
        send_byte(8'hF8, 1'b0);
        settle();
        check_eq("t7_frame_err", 64'(frame_err), 64'd1);
        check_eq("t7_no_entry", 64'(empty), 64'd1);

        // reset mid-byte clears everything including running status
        send_byte(8'hF8, 1'b1);
        send_byte(8'h90, 1'b1);
        settle();
        check_eq("t8_pre_count", 64'(count), 64'd1);
        din = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check_eq("t8_empty", 64'(empty), 64'd1);
        check_eq("t8_full", 64'(full), 64'd0);
        check_eq("t8_count", 64'(count), 64'd0);
        check_eq("t8_overflow", 64'(overflow), 64'd0);
        check_eq("t8_frame_err", 64'(frame_err), 64'd0);
        check_eq("t8_dout", 64'(dout), 64'd0);
        din = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        settle();
        check_eq("t8_no_running", 64'(empty), 64'd1);
        send3(8'h80, 8'h3C, 8'h00);
        settle();
        pop_chk("t8_note_off", 24'h803C00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
